// File: rtl/dff_bank_wr_arbiter_if.sv
// Bus between the requesting datapath stages and the shared-register write arbiter.
// The master side drives requests and data; the slave side returns grant and register status.
interface dff_bank_wr_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned IDW = $clog2(N)
);
  logic             clr;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [IDW-1:0]   owner;
  logic [15:0]      wr_cnt;

  modport master (
    output clr, req, wdata,
    input  gnt, q, q_valid, owner, wr_cnt
  );

  modport slave (
    input  clr, req, wdata,
    output gnt, q, q_valid, owner, wr_cnt
  );
endinterface

// File: rtl/dff_bank_wr_arbiter.sv
// Round-robin write arbiter for a shared W-bit register of enable-gated, async-clear D flip-flops.
// Grants at most one requester per clock and tracks owner, valid flag and a saturating load count.
module dff_bank_wr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  dff_bank_wr_arbiter_if.slave   bus
);

  logic [IDW-1:0] ptr;
  logic [N-1:0]   gnt_r;
  logic [W-1:0]   q_r;
  logic           q_valid_r;
  logic [IDW-1:0] owner_r;
  logic [15:0]    wr_cnt_r;

  logic [N-1:0]   elig;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  int unsigned    cand;
  logic [W-1:0]   wdata_sel;
  logic           load_en;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] ptr_nxt;
  logic [15:0]    wr_cnt_inc;

  // A requester holding gnt this cycle sits out this edge, forcing one-cycle turnaround.
  assign elig = bus.req & ~gnt_r;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!win_found && elig[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    wdata_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_idx == IDW'(i)) begin
        wdata_sel = bus.wdata[i*W +: W];
      end
    end
  end

  assign load_en    = win_found & ~bus.clr;
  assign ptr_nxt    = (win_idx == IDW'(N - 1)) ? '0 : win_idx + 1'b1;
  assign wr_cnt_inc = (wr_cnt_r == '1) ? wr_cnt_r : wr_cnt_r + 16'd1;

  always_comb begin
    gnt_nxt = '0;
    if (load_en) begin
      gnt_nxt[win_idx] = 1'b1;
    end
  end

  // Shared register: one enable-gated flop per bit, async clear on rst, sync clear on clr.
  for (genvar b = 0; b < W; b++) begin : g_bank
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_r[b] <= 1'b0;
      end else if (bus.clr) begin
        q_r[b] <= 1'b0;
      end else if (load_en) begin
        q_r[b] <= wdata_sel[b];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      gnt_r     <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
      wr_cnt_r  <= '0;
    end else if (bus.clr) begin
      gnt_r     <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
      wr_cnt_r  <= '0;
    end else begin
      gnt_r <= gnt_nxt;
      if (load_en) begin
        ptr       <= ptr_nxt;
        q_valid_r <= 1'b1;
        owner_r   <= win_idx;
        wr_cnt_r  <= wr_cnt_inc;
      end
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
  assign bus.wr_cnt  = wr_cnt_r;

endmodule

// File: tb/tb_dff_bank_wr_arbiter.sv
// Directed bench for dff_bank_wr_arbiter (N=4, W=8) with a scoreboard of expected post-edge state.
module tb_dff_bank_wr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  dff_bank_wr_arbiter_if #(.N(N), .W(W)) bus ();

  dff_bank_wr_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        qv;
    logic [1:0]  owner;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  m_q;
  logic        m_qv;
  logic [1:0]  m_owner;
  logic [15:0] m_cnt;
  logic [3:0]  m_gnt;
  int          m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_qv = 1'b0; m_owner = '0; m_cnt = '0; m_gnt = '0; m_ptr = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".q"},      32'(bus.q),       32'h0);
    chk({tag, ".qv"},     32'(bus.q_valid), 32'h0);
    chk({tag, ".owner"},  32'(bus.owner),   32'h0);
    chk({tag, ".cnt"},    32'(bus.wr_cnt),  32'h0);
    chk({tag, ".gnt"},    32'(bus.gnt),     32'h0);
  endtask

  // Reference: rotate the eligible set by ptr and take its lowest set bit.
  task automatic model_edge(input logic c, input logic [3:0] r, input logic [31:0] wd);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [3:0] e;
    int w;
    if (c) begin
      m_q = '0; m_qv = 1'b0; m_owner = '0; m_cnt = '0; m_gnt = '0;
    end else begin
      e   = r & ~m_gnt;
      dbl = {e, e} >> m_ptr;
      rot = dbl[3:0];
      w   = -1;
      for (int j = 3; j >= 0; j--) if (rot[j]) w = (m_ptr + j) % 4;
      if (w >= 0) begin
        m_q     = wd[w*8 +: 8];
        m_gnt   = 4'b0001 << w;
        m_owner = 2'(w);
        m_qv    = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_ptr   = (w + 1) % 4;
      end else begin
        m_gnt = '0;
      end
    end
  endtask

  task automatic step(input logic c, input logic [3:0] r, input string tag, input bit do_chk = 1'b1);
    exp_t e;
    exp_t got;
    bus.clr = c;
    bus.req = r;
    model_edge(c, r, bus.wdata);
    e.tag = tag; e.gnt = m_gnt; e.q = m_q; e.qv = m_qv; e.owner = m_owner; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (do_chk) begin
      chk({got.tag, ".gnt"},   32'(bus.gnt),     32'(got.gnt));
      chk({got.tag, ".q"},     32'(bus.q),       32'(got.q));
      chk({got.tag, ".qv"},    32'(bus.q_valid), 32'(got.qv));
      chk({got.tag, ".owner"}, 32'(bus.owner),   32'(got.owner));
      chk({got.tag, ".cnt"},   32'(bus.wr_cnt),  32'(got.cnt));
    end
  endtask

  initial begin
    rst       = 1'b0;
    bus.clr   = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
    model_reset();

    // Reset asserted mid-cycle, observed before any edge
    #2 rst = 1'b1;
    #1 chk_zero("rst_async");
    @(posedge clk); #1;
    chk_zero("rst_hold");
    #3 rst = 1'b0;

    // Single held requester: grants on alternate cycles
    bus.wdata = 32'h00A5_0000;
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0100, $sformatf("single%0d", i));
    chk("single.q_const",   32'(bus.q),      32'hA5);
    chk("single.cnt_const", 32'(bus.wr_cnt), 32'd2);

    // Pointer wrap: 3 alone, then 0 and 3 contend
    bus.wdata = 32'h3300_0030;
    step(1'b0, 4'b1000, "wrap_a");
    bus.req = '0;
    step(1'b0, 4'b0000, "wrap_idle");
    step(1'b0, 4'b1001, "wrap_b");
    chk("wrap.gnt0", 32'(bus.gnt), 32'h1);
    step(1'b0, 4'b1001, "wrap_c");
    chk("wrap.gnt3", 32'(bus.gnt), 32'h8);

    // Full contention from a cleared counter; ptr is 0 here
    step(1'b1, 4'b0000, "pre_clr");
    bus.wdata = 32'h1312_1110;
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, $sformatf("full%0d", i));
    chk("full.cnt8", 32'(bus.wr_cnt), 32'd8);

    // Async reset mid-burst after requester 1 is granted
    step(1'b0, 4'b1111, "burst0");
    step(1'b0, 4'b1111, "burst1");
    chk("burst.gnt1", 32'(bus.gnt), 32'h2);
    #2 rst = 1'b1;
    #1 chk_zero("burst_rst");
    model_reset();
    #1 rst = 1'b0;
    step(1'b0, 4'b1111, "burst_after");
    chk("burst.first0", 32'(bus.gnt), 32'h1);

    // clr beats simultaneous requests and leaves ptr alone
    bus.req = '0;
    step(1'b0, 4'b0000, "clr_idle");
    bus.wdata = 32'h0000_005A;
    step(1'b0, 4'b0001, "clr_load");
    chk("clr.q5a", 32'(bus.q), 32'h5A);
    step(1'b1, 4'b0011, "clr_edge");
    step(1'b0, 4'b0011, "clr_next");
    chk("clr.ptr_kept", 32'(bus.gnt), 32'h2);

    // Saturation of the load counter
    step(1'b1, 4'b0000, "sat_clr");
    bus.wdata = 32'h0000_4433;
    for (int k = 0; k < 65537; k++)
      step(1'b0, 4'b0011, $sformatf("sat%0d", k), (k < 3) || (k > 65532));
    chk("sat.cnt_max", 32'(bus.wr_cnt), 32'hFFFF);
    step(1'b0, 4'b0011, "sat_extra");
    chk("sat.cnt_hold", 32'(bus.wr_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_bank_wr_arbiter.md
# dff_bank_wr_arbiter

Round-robin write arbiter and sequencer for a shared W-bit register built from enable-gated D flip-flops with asynchronous clear. N requesters compete to load the register. The block grants at most one requester per clock, drives the register's enable and data, and reports which requester wrote last. It sits between the requesting datapath stages and the shared register, which is instantiated inside this block.

## Interface
- N, 4: number of requesters; legal range is 2..8.
- W, 8: width of the shared register in bits.
- IDW, $clog2(N): width of the owner field.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- clr  in  1  synchronous clear of the register and status; has priority over all requests.
- req  in  N  per-requester write request; bit i belongs to requester i.
- wdata  in  N*W  packed write data; requester i uses bits [i*W +: W].
- gnt  out  N  registered one-hot grant; high for exactly one cycle, in the cycle after the winning edge.
- q  out  W  shared register contents.
- q_valid  out  1  high once the register has been loaded since the last rst or clr.
- owner  out  IDW  index of the requester that performed the most recent load.
- wr_cnt  out  16  saturating count of completed loads.

## Operation
- State: priority pointer ptr (IDW bits), gnt register, q register, q_valid, owner, wr_cnt.
- Eligible set at each rising edge: E[i] = req[i] & ~gnt[i]. A requester granted in the current cycle is ignored at this edge. This gives a one-cycle turnaround, so a held req receives at most one grant every other cycle.
- Winner selection: the first index i with E[i]=1, searched in order ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
- Edge with clr=1:
  - q←0, q_valid←0, owner←0, wr_cnt←0, gnt←0.
  - ptr is unchanged.
  - All requests are ignored and none are queued.
- Edge with clr=0 and a winner w:
  - q←wdata[w*W +: W] (register enable=1).
  - gnt←one-hot(w), owner←w, q_valid←1.
  - wr_cnt←wr_cnt+1, saturating at 16'hFFFF.
  - ptr←(w+1) mod N, wrapping from N-1 to 0.
- Edge with clr=0 and no eligible request:
  - gnt←0.
  - q, q_valid, owner, wr_cnt and ptr hold (register enable=0).
- Requester protocol:
  - A requester keeps req high until it sees its gnt bit.
  - Data must be stable while req is high.
  - The load happens at the same edge that raises gnt, so the data was captured when gnt becomes visible.
  - Keeping req high after gnt is a new request.
- rst=1, asynchronous, at any time (including mid-burst):
  - Immediately forces q=0, q_valid=0, owner=0, wr_cnt=0, gnt=0, ptr=0.
  - Operation resumes at the first rising edge after rst falls.
- Invariants:
  - gnt is always zero or one-hot.
  - q changes only at edges where gnt becomes nonzero, or on clr/rst.

## Timing
- Latency: req sampled at edge k produces q, owner, wr_cnt and gnt updates visible after edge k, all in the same cycle. Grant latency is one cycle from the req setup.
- Throughput: one load per cycle when at least two requesters are active. With a single active held requester, loads occur on alternate cycles: gnt pattern 1,0,1,0.
- Fairness: with all N requests held continuously, every requester is granted exactly once in any N consecutive grants.
- Reset values: q=0, q_valid=0, owner=0, wr_cnt=0, gnt=0, ptr=0.
- Simultaneous clr and req: clr wins, with no grant and no load.
- req deasserted before its grant: nothing is granted to it and no state is left behind.
- wr_cnt at 16'hFFFF stays at 16'hFFFF on further loads.

## Test plan
- Reset, then a single request:
  - Stimulus: assert rst mid-cycle, release it; then hold req=4'b0100 with wdata[2]=8'hA5 for 4 cycles.
  - Response: outputs go to zero immediately on rst; afterwards gnt=0100,0000,0100,0000; q=8'hA5; owner=2; wr_cnt counts 1,1,2,2.
- Full contention:
  - Stimulus: req=4'b1111 held for 8 cycles, with wdata[i]=8'h10+i.
  - Response: grant order 0,1,2,3,0,1,2,3; q follows 10,11,12,13,…; wr_cnt reaches 8.
- Pointer wrap:
  - Stimulus: grant requester 3 alone, then req=4'b1001.
  - Response: the next grant goes to requester 0, then 3.
- clr priority:
  - Stimulus: clr=1 together with req=4'b0011 at an edge when q=8'h5A.
  - Response: q=0, q_valid=0, wr_cnt=0, gnt=0, ptr unchanged; the next edge with clr=0 grants according to the unchanged ptr.
- Async reset mid-burst:
  - Stimulus: rst pulsed between edges during full contention, after requester 1 has been granted.
  - Response: outputs are zero before the next edge; after release, the first grant goes to requester 0.
- Saturation:
  - Stimulus: run req=4'b0011 for 65537 loads.
  - Response: wr_cnt stops at 16'hFFFF while q and owner keep updating.
